// File: rtl/div_iter_param.sv
// Iterative restoring divider for DIV/DIVU, retiring BITS_PER_CYCLE quotient bits per cycle.
// Produces {remainder, quotient}; a zero divisor is flagged alongside ready_o.
module div_iter_param #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int unsigned N_ITER = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               signed_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               busy_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   op1_mag_c;
  logic [WIDTH-1:0]   op2_mag_c;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   dvd_d;
  logic [WIDTH:0]     trial_c;
  logic [WIDTH:0]     diff_c;
  logic [WIDTH-1:0]   quot_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  // Operand magnitudes; only signed divides with a set MSB are negated.
  assign op1_mag_c = (signed_div_i && opdata1_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
  assign op2_mag_c = (signed_div_i && opdata2_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

  // Cascaded restoring steps on the {partial remainder, dividend} shift pair.
  always_comb begin
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    trial_c = '0;
    diff_c  = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      trial_c = {rem_d, dvd_d[WIDTH-1]};
      diff_c  = trial_c - {1'b0, dsr_q};
      rem_d   = diff_c[WIDTH] ? trial_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
      dvd_d   = {dvd_d[WIDTH-2:0], ~diff_c[WIDTH]};
    end
  end

  // Wrap-around sign fix makes MIN / -1 come out as MIN with remainder 0.
  assign quot_fix_c = (signed_q && (sign1_q ^ sign2_q)) ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
  assign rem_fix_c  = (signed_q && sign1_q) ? ({WIDTH{1'b0}} - rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          dbz_q    <= 1'b0;
          if (start_i && !annul_i) begin
            busy_q <= 1'b1;
            if (opdata2_i == '0) begin
              state_q <= DIV_BY_ZERO;
            end else begin
              state_q  <= DIV_ON;
              rem_q    <= '0;
              dvd_q    <= op1_mag_c;
              dsr_q    <= op2_mag_c;
              sign1_q  <= opdata1_i[WIDTH-1];
              sign2_q  <= opdata2_i[WIDTH-1];
              signed_q <= signed_div_i;
              cnt_q    <= '0;
            end
          end
        end
        // ready_o rises one cycle after entering DIV_END on this path (2-cycle latency).
        DIV_BY_ZERO: begin
          state_q  <= DIV_END;
          busy_q   <= 1'b0;
          dbz_q    <= 1'b1;
          result_q <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(N_ITER)) begin
            state_q  <= DIV_END;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= {rem_fix_c, quot_fix_c};
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o      = result_q;
  assign ready_o       = ready_q;
  assign busy_o        = busy_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboarded bench for div_iter_param: 32-bit radix-2 directed cases and 8-bit radix-4 random sweep.
module tb_div_iter_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_signed, a_start, a_annul;
  logic [31:0] a_op1, a_op2;
  logic [63:0] a_result;
  logic        a_ready, a_busy, a_dbz;

  logic        b_signed, b_start, b_annul;
  logic [7:0]  b_op1, b_op2;
  logic [15:0] b_result;
  logic        b_ready, b_busy, b_dbz;

  div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .signed_div_i(a_signed), .opdata1_i(a_op1), .opdata2_i(a_op2),
    .start_i(a_start), .annul_i(a_annul), .result_o(a_result), .ready_o(a_ready),
    .busy_o(a_busy), .div_by_zero_o(a_dbz)
  );

  div_iter_param #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut_b (
    .clk(clk), .rst(rst), .signed_div_i(b_signed), .opdata1_i(b_op1), .opdata2_i(b_op2),
    .start_i(b_start), .annul_i(b_annul), .result_o(b_result), .ready_o(b_ready),
    .busy_o(b_busy), .div_by_zero_o(b_dbz)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit divide, scramble operands after acceptance, check result, hold and release.
  task automatic run_a(input string tag, input logic sgn, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp_res, input logic exp_dbz, input int exp_lat,
                       input int exp_busy);
    exp_t e;
    int   n;
    int   nb;
    a_signed = sgn; a_op1 = x; a_op2 = y; a_start = 1'b1;
    sb.push_back('{exp_res, exp_dbz, exp_lat, exp_busy});
    n = 0; nb = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        a_op1 = $urandom; a_op2 = $urandom; a_signed = ~sgn;
      end
      if (a_busy) nb++;
    end while (!a_ready && n < 100);
    e = sb.pop_front();
    check({tag, "_latency"}, 64'(n - 1), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(e.busy));
    check({tag, "_result"}, a_result, e.res);
    check({tag, "_dbz"}, 64'(a_dbz), 64'(e.dbz));
    tick(); tick();
    check({tag, "_hold_ready"}, 64'(a_ready), 64'd1);
    check({tag, "_hold_result"}, a_result, e.res);
    a_start = 1'b0;
    tick();
    check({tag, "_release_ready"}, 64'(a_ready), 64'd0);
    check({tag, "_release_result"}, a_result, 64'd0);
    check({tag, "_release_dbz"}, 64'(a_dbz), 64'd0);
  endtask

  function automatic logic [15:0] ref8(input logic sgn, input logic [7:0] x, input logic [7:0] y);
    int          q;
    int          r;
    logic [31:0] qv;
    logic [31:0] rv;
    if (y == 8'd0) return 16'd0;
    if (sgn) begin
      q = int'($signed(x)) / int'($signed(y));
      r = int'($signed(x)) % int'($signed(y));
    end else begin
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
    end
    qv = q;
    rv = r;
    return {rv[7:0], qv[7:0]};
  endfunction

  task automatic run_b(input logic sgn, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   n;
    b_signed = sgn; b_op1 = x; b_op2 = y; b_start = 1'b1;
    sb.push_back('{64'(ref8(sgn, x, y)), (y == 8'd0), ((y == 8'd0) ? 2 : 5), 0});
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        b_op1 = 8'($urandom); b_op2 = 8'($urandom);
      end
    end while (!b_ready && n < 50);
    e = sb.pop_front();
    check("rand_latency", 64'(n - 1), 64'(e.lat));
    check("rand_result", 64'(b_result), e.res);
    check("rand_dbz", 64'(b_dbz), 64'(e.dbz));
    b_start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    a_signed = 1'b0; a_op1 = '0; a_op2 = '0; a_start = 1'b0; a_annul = 1'b0;
    b_signed = 1'b0; b_op1 = '0; b_op2 = '0; b_start = 1'b0; b_annul = 1'b0;
    tick(); tick();
    check("reset_result", a_result, 64'd0);
    check("reset_ready", 64'(a_ready), 64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    check("reset_dbz", 64'(a_dbz), 64'd0);
    rst = 1'b1;
    tick();

    run_a("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 33);
    run_a("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33, 33);
    run_a("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 33, 33);
    run_a("u_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 1'b0, 33, 33);
    run_a("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 33, 33);
    run_a("div_zero", 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 2, 1);

    // Annul in the 10th DIV_ON cycle, then confirm no result ever appears.
    a_signed = 1'b0; a_op1 = 32'd1000; a_op2 = 32'd3; a_start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    a_annul = 1'b1;
    tick();
    a_annul = 1'b0; a_start = 1'b0;
    check("annul_busy", 64'(a_busy), 64'd0);
    check("annul_ready", 64'(a_ready), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (a_ready) seen++;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
    end
    check("annul_result", a_result, 64'd0);
    run_a("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33, 33);

    // Synchronous reset in the middle of a divide.
    a_signed = 1'b0; a_op1 = 32'd100; a_op2 = 32'd7; a_start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0; a_start = 1'b0;
    tick();
    check("midrst_result", a_result, 64'd0);
    check("midrst_ready", 64'(a_ready), 64'd0);
    check("midrst_busy", 64'(a_busy), 64'd0);
    check("midrst_dbz", 64'(a_dbz), 64'd0);
    rst = 1'b1;
    tick();
    run_a("after_rst_u50_6", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 1'b0, 33, 33);

    // 8-bit radix-4 sweep with corner cases first.
    run_b(1'b1, 8'h80, 8'hFF);
    run_b(1'b0, 8'hFF, 8'h01);
    run_b(1'b1, 8'h81, 8'h00);
    run_b(1'b1, 8'h80, 8'h7F);
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = 8'($urandom);
      y = (i % 64 == 0) ? 8'd0 : 8'($urandom);
      run_b(1'($urandom_range(0, 1)), x, y);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
